// File: rtl/dct_blk_loader.sv
// Serial-to-block loader feeding the 4-point DCT: ping-pong buffers group samples into N-wide blocks.
// Optional DC level shift (s_data_i - 128) is enabled by defining DCT_LVL_SHIFT_EN.
module dct_blk_loader #(
  parameter int N  = 4,
  parameter int DW = 8
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            s_valid_i,
  output logic            s_ready_o,
  input  logic [DW-1:0]   s_data_i,
  input  logic            s_last_i,
  output logic            blk_valid_o,
  input  logic            blk_ready_i,
  output logic [N*DW-1:0] blk_o,
  output logic            blk_pad_o
);

  localparam int IW = (N > 1) ? $clog2(N) : 1;
  localparam logic [IW-1:0] IDX_LAST = IW'(N - 1);

  logic [DW-1:0] bank_reg [2][N];
  logic [1:0]    full_reg;
  logic [1:0]    pad_reg;
  logic          wr_bank_reg;
  logic          rd_bank_reg;
  logic [IW-1:0] wr_idx_reg;
  logic [DW-1:0] wr_data;
  logic          accept;
  logic          transfer;

`ifdef DCT_LVL_SHIFT_EN
  // Subtracting 128 from an unsigned byte is the same as flipping its MSB.
  assign wr_data = {~s_data_i[DW-1], s_data_i[DW-2:0]};
`else
  assign wr_data = s_data_i;
`endif

  // Ready depends only on registered state, never on blk_ready_i.
  assign s_ready_o   = !rst_i && !full_reg[wr_bank_reg];
  assign blk_valid_o = !rst_i && full_reg[rd_bank_reg];
  assign blk_pad_o   = pad_reg[rd_bank_reg];
  assign accept      = s_valid_i && s_ready_o;
  assign transfer    = blk_valid_o && blk_ready_i;

  generate
    for (genvar gi = 0; gi < N; gi++) begin : g_out
      assign blk_o[gi*DW +: DW] = bank_reg[rd_bank_reg][gi];
    end
  endgenerate

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      full_reg    <= '0;
      pad_reg     <= '0;
      wr_bank_reg <= 1'b0;
      rd_bank_reg <= 1'b0;
      wr_idx_reg  <= '0;
      for (int b = 0; b < 2; b++) begin
        for (int i = 0; i < N; i++) begin
          bank_reg[b][i] <= '0;
        end
      end
    end else begin
      // Accept only targets a non-full bank and transfer only a full one,
      // so the two never touch the same full bit.
      if (accept) begin
        bank_reg[wr_bank_reg][wr_idx_reg] <= wr_data;
        if (wr_idx_reg == IDX_LAST || s_last_i) begin
          for (int i = 0; i < N; i++) begin
            if (i > int'(wr_idx_reg)) begin
              bank_reg[wr_bank_reg][i] <= '0;
            end
          end
          full_reg[wr_bank_reg] <= 1'b1;
          pad_reg[wr_bank_reg]  <= (wr_idx_reg != IDX_LAST);
          wr_idx_reg            <= '0;
          wr_bank_reg           <= ~wr_bank_reg;
        end else begin
          wr_idx_reg <= wr_idx_reg + IW'(1);
        end
      end
      if (transfer) begin
        full_reg[rd_bank_reg] <= 1'b0;
        rd_bank_reg           <= ~rd_bank_reg;
      end
    end
  end

endmodule

// File: doc/dct_blk_loader.md
Name: dct_blk_loader

Overview:
- Upstream feeder for the 4-point DCT chain (direct transform -> renorm -> inverse transform).
- Accepts a serial stream of 8-bit samples over a valid/ready handshake and groups them into 4-sample blocks.
- Presents each complete block in parallel, in the signed 8-bit x4 format the direct-transform input expects.
- Ping-pong (two-bank) buffering sustains one sample per clock while a completed block waits for the consumer.

Parameters:
- N, 4, samples per block; must equal the DCT point count (only 4 supported).
- DW, 8, sample width in bits; must match the DCT input width.

Ports:
- clk_i  input  1  clock; all logic on the rising edge.
- rst_i  input  1  reset, synchronous, active-high.
- s_valid_i  input  1  input sample valid.
- s_ready_o  output  1  loader can accept a sample.
- s_data_i  input  DW  input sample.
- s_last_i  input  1  marks the final sample of a stream segment; the current block is closed and zero-padded.
- blk_valid_o  output  1  complete block available.
- blk_ready_i  input  1  consumer takes the block.
- blk_o  output  N x DW signed  block samples; index 0 is the oldest sample. Connects to the DCT input.
- blk_pad_o  output  1  presented block was zero-padded (closed early by s_last_i).

Behaviour:
- State:
  - bank[2][N] of DW bits, plus a pad bit per bank.
  - full[2]; wr_bank, rd_bank (1 bit each); wr_idx (0..N-1).
- Reset (rst_i high at a clock edge):
  - full=0, wr_bank=rd_bank=0, wr_idx=0, bank contents=0, pad bits=0.
  - s_ready_o=0 and blk_valid_o=0 while rst_i is high.
  - blk_o=0 and blk_pad_o=0 after reset.
  - Reset mid-block or with full banks discards all buffered data; no block is emitted.
- s_ready_o = !rst_i && !full[wr_bank]. Combinational from registered state only; no combinational path from blk_ready_i.
- Accept: s_valid_i && s_ready_o at an edge.
  - Write bank[wr_bank][wr_idx] <= s_data_i (after the optional transform).
  - If wr_idx==N-1: full[wr_bank]<=1, pad<=0, wr_idx<=0, wr_bank toggles.
  - Else if s_last_i:
    - Write entries wr_idx+1..N-1 of the same bank to 0 in the same cycle.
    - full<=1, pad<=1, wr_idx<=0, wr_bank toggles.
  - Else: wr_idx increments.
  - s_last_i on the N-th sample is a normal close (pad=0).
  - s_last_i and s_data_i are ignored when no accept occurs.
- Output:
  - blk_valid_o = full[rd_bank]; blk_o = bank[rd_bank]; blk_pad_o = pad[rd_bank].
  - Transfer: blk_valid_o && blk_ready_i at an edge clears full[rd_bank] and toggles rd_bank.
- Hold rule: while blk_valid_o && !blk_ready_i, blk_o and blk_pad_o stay stable.
- Latency: the block is valid on the cycle after its closing sample is accepted.
- Throughput: 1 sample/clk with blk_ready_i held high; s_ready_o never drops.
- Both banks full: s_ready_o=0 until a transfer.
  - A transfer in cycle t raises s_ready_o in t+1.
  - There is no same-cycle pass-through; this is the intended registered behaviour.
- Block close and output transfer in the same cycle are on different banks; both take effect.
- Bank count/ordering: blocks leave in arrival order; none is dropped or duplicated.

Optional Feature:
- Macro: DCT_LVL_SHIFT_EN.
- Defined:
  - s_data_i is treated as unsigned 0..255.
  - The stored value is s_data_i - 128, i.e. MSB inverted, range -128..127. This is the DC level shift ahead of the DCT.
  - Pad entries are still stored as 0 (post-shift zero).
- Not defined: s_data_i is stored unchanged and reinterpreted as signed.

Test Plan:
- Reset, then samples 10,20,30,40 with blk_ready_i=1 and no shift:
  - blk_valid_o rises the cycle after 40 is accepted.
  - blk_o = {10,20,30,40}, blk_pad_o=0, held for 1 cycle.
- 12 consecutive samples 1..12, one per cycle, blk_ready_i=1:
  - s_ready_o stays high throughout.
  - Blocks {1,2,3,4}, {5,6,7,8}, {9,10,11,12} appear on consecutive 4-cycle spacing.
- blk_ready_i=0 while 10 samples are offered:
  - After 8 samples are accepted, s_ready_o=0 and blk_o is stable at {s0..s3}.
  - Raise blk_ready_i for 1 cycle: the block transfers, s_ready_o=1 next cycle, then {s4..s7} is presented.
- Samples 7,-3 with s_last_i on -3:
  - blk_o = {7,-3,0,0}, blk_pad_o=1.
  - The next block starts at index 0.
- Reset asserted after 2 samples of a block and with one full bank pending:
  - blk_valid_o=0 and s_ready_o=0 during reset.
  - After release, samples 5,6,7,8 give exactly one block {5,6,7,8}.
- With DCT_LVL_SHIFT_EN defined, input 0,128,255,200:
  - blk_o = {-128,0,127,72}.
